// File: rtl/clk_prescaler.sv
// ---------------------------------------------------------------------------
// clk_prescaler
//   Free-running binary prescaler. An N-bit up-counter advances on every
//   enabled clk edge. The counter MSB is a 50% duty-cycle divided clock with
//   period 2^N. A single-cycle tick marks the last enabled cycle of each
//   period. The raw count is also exported for logic in the clk domain.
//
//   out is taken straight from a flop, so it is glitch-free. It may clock
//   slow scan logic. Logic that stays in the clk domain should use tick as a
//   clock enable instead of clocking from out.
// ---------------------------------------------------------------------------
module clk_prescaler #(
    parameter int unsigned N = 16        // counter width, legal range 1..32
) (
    input  logic         clk,
    input  logic         reset,          // asynchronous, active-high
    input  logic         en,             // high = advance, low = hold
    output logic         out,            // divided clock, period 2^N cycles
    output logic         tick,           // last enabled cycle of each period
    output logic [N-1:0] count           // current counter value
);

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;

    // Next-state: advance by one when enabled (natural wrap modulo 2^N), else hold.
    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + N'(1);
        end
    end

    // Counter register with asynchronous clear; the phase is discarded on reset.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Outputs: out is the register MSB (no extra latency), tick is the
    // enabled all-ones cycle, masked while reset is held high.
    always_comb begin
        count = count_q;
        out   = count_q[N-1];
        tick  = en & (&count_q) & ~reset;
    end

endmodule

// File: tb/tb_clk_prescaler.sv
// ---------------------------------------------------------------------------
// tb_clk_prescaler
//   Three instances (N=4, N=16, N=1) on a shared clock. Inputs change 1 time
//   unit after a rising edge; outputs are sampled on the falling edge.
//   Expected values for the N=4 instance come from a small reference model.
//   Each step pushes them into a scoreboard queue, and the queue is popped
//   when the outputs are sampled.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clk_prescaler;

    typedef struct {
        logic [3:0] count;
        logic       out;
        logic       tick;
    } exp_t;

    logic clk;
    logic reset4,  en4;
    logic reset16, en16;
    logic reset1,  en1;

    logic        out4,  tick4;
    logic [3:0]  count4;
    logic        out16, tick16;
    logic [15:0] count16;
    logic        out1,  tick1;
    logic [0:0]  count1;

    int checks   = 0;
    int failures = 0;

    exp_t       sb4[$];
    logic [3:0] m4;         // reference model of the N=4 counter

    clk_prescaler #(.N(4)) u_dut4 (
        .clk(clk), .reset(reset4), .en(en4),
        .out(out4), .tick(tick4), .count(count4)
    );

    clk_prescaler #(.N(16)) u_dut16 (
        .clk(clk), .reset(reset16), .en(en16),
        .out(out16), .tick(tick16), .count(count16)
    );

    clk_prescaler #(.N(1)) u_dut1 (
        .clk(clk), .reset(reset1), .en(en1),
        .out(out1), .tick(tick1), .count(count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One N=4 cycle: drive en, push the expected outputs, compare them at the
    // falling edge, then advance the model across the rising edge.
    task automatic step4(input logic en_v, input string tag);
        exp_t e;
        exp_t got;
        en4     = en_v;
        e.count = m4;
        e.out   = m4[3];
        e.tick  = en_v && (m4 == 4'hF);
        sb4.push_back(e);
        @(negedge clk);
        got = sb4.pop_front();
        checks++;
        if (count4 !== got.count) begin
            failures++;
            $display("FAIL %s count4: got %0d expected %0d", tag, count4, got.count);
        end
        checks++;
        if (out4 !== got.out) begin
            failures++;
            $display("FAIL %s out4: got %b expected %b (count %0d)", tag, out4, got.out, got.count);
        end
        checks++;
        if (tick4 !== got.tick) begin
            failures++;
            $display("FAIL %s tick4: got %b expected %b (count %0d)", tag, tick4, got.tick, got.count);
        end
        @(posedge clk);
        if (en_v) m4 = m4 + 4'd1;
        #1;
    endtask

    // Asynchronous reset on every instance. The counters clear before any clock
    // edge, and they stay cleared while reset is high even with en=1.
    task automatic test_reset();
        reset4 = 1'b0; reset16 = 1'b0; reset1 = 1'b0;
        en4 = 1'b0; en16 = 1'b0; en1 = 1'b0;
        #2;
        reset4 = 1'b1; reset16 = 1'b1; reset1 = 1'b1;
        #1;
        checks++;
        if (count4 !== 4'd0 || out4 !== 1'b0 || tick4 !== 1'b0) begin
            failures++;
            $display("FAIL reset_async_n4: got count=%0d out=%b tick=%b expected 0/0/0", count4, out4, tick4);
        end
        checks++;
        if (count16 !== 16'd0 || out16 !== 1'b0 || tick16 !== 1'b0) begin
            failures++;
            $display("FAIL reset_async_n16: got count=%0d out=%b tick=%b expected 0/0/0", count16, out16, tick16);
        end
        checks++;
        if (count1 !== 1'b0 || out1 !== 1'b0 || tick1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_async_n1: got count=%0d out=%b tick=%b expected 0/0/0", count1, out1, tick1);
        end
        en4 = 1'b1; en16 = 1'b1; en1 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (count4 !== 4'd0 || out4 !== 1'b0 || tick4 !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold_n4: got count=%0d out=%b tick=%b expected 0/0/0", count4, out4, tick4);
        end
        checks++;
        if (count1 !== 1'b0 || tick1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold_n1: got count=%0d tick=%b expected 0/0", count1, tick1);
        end
        en4 = 1'b0; en16 = 1'b0; en1 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // N=4, 32 enabled cycles from reset: count i%16, out low 0-7 and high
    // 8-15, exactly two ticks at cycles 15 and 31.
    task automatic test_sequence_n4();
        int n_ticks;
        int tick_at[$];
        reset4 = 1'b0;
        m4 = 4'd0;
        n_ticks = 0;
        for (int i = 0; i < 32; i++) begin
            en4 = 1'b1;
            @(negedge clk);
            if (tick4 === 1'b1) begin
                n_ticks++;
                tick_at.push_back(i);
            end
            checks++;
            if (count4 !== 4'(i % 16) || out4 !== ((i % 16) >= 8)) begin
                failures++;
                $display("FAIL seq_n4 cycle %0d: got count=%0d out=%b expected count=%0d out=%b",
                         i, count4, out4, i % 16, (i % 16) >= 8);
            end
            @(posedge clk);
            #1;
        end
        m4 = 4'd0;
        checks++;
        if (n_ticks !== 2) begin
            failures++;
            $display("FAIL seq_n4 tick count: got %0d expected 2", n_ticks);
        end
        checks++;
        if (tick_at.size() != 2 || tick_at[0] != 15 || tick_at[1] != 31) begin
            failures++;
            $display("FAIL seq_n4 tick cycles: got %p expected '{15, 31}", tick_at);
        end
    endtask

    // N=4 enable gating: hold at 6 for 5 cycles, then hold at 15 with tick
    // suppressed until en returns.
    task automatic test_enable_hold_n4();
        for (int i = 0; i < 6; i++) step4(1'b1, "hold_ramp");
        for (int i = 0; i < 5; i++) step4(1'b0, "hold_at_6");
        step4(1'b1, "resume_6");
        step4(1'b1, "resume_7");
        for (int i = 0; i < 16 && m4 != 4'hF; i++) step4(1'b1, "ramp_15");
        for (int i = 0; i < 3; i++) step4(1'b0, "hold_at_15");
        step4(1'b1, "tick_after_hold");
        step4(1'b1, "wrap_to_0");
    endtask

    // Reset asserted between edges at count 11: the counter clears at once,
    // and it restarts from 0 at the first edge after release.
    task automatic test_async_reset_n4();
        while (m4 != 4'd11) step4(1'b1, "ramp_11");
        en4 = 1'b1;
        @(negedge clk);
        checks++;
        if (count4 !== 4'd11) begin
            failures++;
            $display("FAIL async_pre count4: got %0d expected 11", count4);
        end
        reset4 = 1'b1;
        #1;
        checks++;
        if (count4 !== 4'd0 || out4 !== 1'b0 || tick4 !== 1'b0) begin
            failures++;
            $display("FAIL async_clear: got count=%0d out=%b tick=%b expected 0/0/0", count4, out4, tick4);
        end
        reset4 = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (count4 !== 4'd1) begin
            failures++;
            $display("FAIL async_release count4: got %0d expected 1", count4);
        end
        m4 = 4'd1;
        step4(1'b1, "post_reset");
        step4(1'b1, "post_reset");
        checks++;
        if (sb4.size() != 0) begin
            failures++;
            $display("FAIL scoreboard drain: got %0d entries expected 0", sb4.size());
        end
    endtask

    // N=1: out toggles every enabled cycle, and tick fires whenever count=1
    // with en=1.
    task automatic test_n1();
        reset1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            en1 = 1'b1;
            @(negedge clk);
            checks++;
            if (out1 !== 1'(i % 2) || count1 !== 1'(i % 2) || tick1 !== 1'(i % 2)) begin
                failures++;
                $display("FAIL n1 cycle %0d: got out=%b count=%0d tick=%b expected %0d/%0d/%0d",
                         i, out1, count1, tick1, i % 2, i % 2, i % 2);
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);         // en still 1: count 0 -> 1
        #1;
        en1 = 1'b0;
        @(negedge clk);
        checks++;
        if (count1 !== 1'b1 || tick1 !== 1'b0) begin
            failures++;
            $display("FAIL n1 hold: got count=%0d tick=%b expected 1/0", count1, tick1);
        end
        @(posedge clk);
        #1;
        en1 = 1'b1;
        @(negedge clk);
        checks++;
        if (tick1 !== 1'b1) begin
            failures++;
            $display("FAIL n1 resume tick: got %b expected 1", tick1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (count1 !== 1'b0) begin
            failures++;
            $display("FAIL n1 wrap: got count=%0d expected 0", count1);
        end
        en1 = 1'b0;
    endtask

    // N=16: one full period of 65536 enabled cycles. The period has 32768 low
    // cycles then 32768 high cycles, with a single tick on the last cycle.
    task automatic test_n16();
        int lows, highs, bad_out, n_ticks, tick_cycle;
        lows = 0; highs = 0; bad_out = 0; n_ticks = 0; tick_cycle = -1;
        reset16 = 1'b0;
        en16 = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
            if (out16 === 1'b0) lows++;
            if (out16 === 1'b1) highs++;
            if (out16 !== (i >= 32768)) bad_out++;
            if (tick16 === 1'b1) begin
                n_ticks++;
                tick_cycle = i;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (lows !== 32768 || highs !== 32768) begin
            failures++;
            $display("FAIL n16 duty: got low=%0d high=%0d expected 32768/32768", lows, highs);
        end
        checks++;
        if (bad_out !== 0) begin
            failures++;
            $display("FAIL n16 out phase: got %0d misplaced cycles expected 0", bad_out);
        end
        checks++;
        if (n_ticks !== 1 || tick_cycle !== 65535) begin
            failures++;
            $display("FAIL n16 tick: got %0d ticks at cycle %0d expected 1 at 65535", n_ticks, tick_cycle);
        end
        checks++;
        if (count16 !== 16'd0 || out16 !== 1'b0) begin
            failures++;
            $display("FAIL n16 wrap: got count=%0d out=%b expected 0/0", count16, out16);
        end
        en16 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequence_n4();
        test_enable_hold_n4();
        test_async_reset_n4();
        test_n1();
        test_n16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
